gfx_rom_arbiter: RTL and testbench
==================================

# gfx_rom_arbiter

Four-port read responder for the graphics ROM SDRAM. It answers the CS/ADDR → OK/DOUT handshake issued by the GP9001 tile-address translator: one sprite port and three scroll ports. It serialises those requests onto a single-outstanding SDRAM read channel using round-robin arbitration. It sits between the tile translator and the SDRAM controller, in the 96 MHz domain.

## Interface
- AW, 22, word address width of each port and of the memory channel
- DW, 32, data width
- CLK96  in  1  96 MHz clock; all logic is on its rising edge
- RESET96_N  in  1  asynchronous, active-low reset
- P_CS  in  4  per-port request (bit 0 sprite, bits 1-3 scroll 0-2)
- P_ADDR  in  4×AW  per-port word address (flattened, port n at [n*AW +: AW])
- P_OK  out  4  per-port data-valid/acknowledge
- P_DOUT  out  4×DW  per-port read data, raw and undecoded
- MEM_REQ  out  1  read request to the SDRAM controller
- MEM_ADDR  out  AW  read address
- MEM_RDY  in  1  one-cycle pulse; MEM_DATA is valid in the same cycle
- MEM_DATA  in  DW  read data

## Operation
- Port protocol, requester side:
  - The requester raises CS[n] with ADDR stable.
  - It holds CS[n] until it samples OK[n]=1, then drops CS[n] for at least 1 cycle.
  - ADDR may change only while CS[n]=0.
- Port n is pending when CS[n]=1, OK[n]=0, and the port is not currently granted.
- FSM states:
  - IDLE: if any port is pending, pick a winner by round-robin, starting from the port after the last granted one. Latch its index and address, then go to ISSUE.
  - ISSUE: MEM_REQ=1 and MEM_ADDR=latched address. On MEM_RDY, latch MEM_DATA into P_DOUT[winner], then go to DONE.
  - DONE: set OK[winner]=1 (unless the request was aborted), advance the round-robin pointer, and return to IDLE.
- OK[n] stays high while CS[n] stays high. It clears the cycle after CS[n] is sampled low.
- P_DOUT[n] holds its value until port n's next completion.
- Abort: if CS[winner] drops while in ISSUE, the memory read still completes. The data is discarded, OK is not raised, and P_DOUT is unchanged.
- At most one memory read is outstanding. MEM_REQ deasserts in the cycle after MEM_RDY.
- Reset (asynchronous):
  - Outputs: P_OK=0, P_DOUT=0, MEM_REQ=0, MEM_ADDR=0.
  - Internal: FSM=IDLE, round-robin pointer=3 (so port 0 is served first), cache valid bits=0.
  - Reset asserted mid-transaction: no OK is raised for that transaction. A MEM_RDY arriving after release with no outstanding request is ignored.

## Timing
- Cycle 0: CS[n] is sampled high in IDLE.
- Cycle 1: MEM_REQ=1.
- Cycle k: MEM_RDY=1.
- Cycle k+1: OK[n]=1 and DOUT is valid.
- Minimum latency is 2 cycles, when MEM_RDY arrives in cycle 1.
- Back-to-back service: the next winner is chosen in the IDLE cycle following DONE, so the minimum memory-request spacing is 3 cycles.
- All four ports raised simultaneously from reset: service order is 0,1,2,3.
- MEM_RDY in the same cycle CS[winner] falls counts as an abort.

## Configuration
- GFX_ARB_CACHE_EN defined:
  - Each port keeps a last-address tag and a valid bit.
  - A pending port whose ADDR equals its tag gets OK the next cycle, directly from the IDLE evaluation, without a memory access or an FSM transition. Its P_DOUT is unchanged.
  - A cache hit does not consume or advance the round-robin pointer.
  - The tag is written on every completed, non-aborted memory read.
- Undefined: every request performs a memory read. Tag logic is absent.

## Test plan
- Single request, port 2, ADDR=0x12345, MEM_RDY on cycle 3 with DATA=0xDEADBEEF → MEM_ADDR=0x12345 on cycle 1; OK[2]=1 on cycle 4 with P_DOUT[2]=0xDEADBEEF; OK[2]=0 the cycle after CS[2] falls.
- All four CS high from reset, MEM_RDY fixed at 2 cycles after MEM_REQ → MEM_ADDR order is port 0,1,2,3; no port starves; each OK is held until its CS drops.
- Abort: CS[1] dropped during ISSUE → MEM_RDY is absorbed, OK[1] stays 0, P_DOUT[1] keeps its old value, and the FSM next serves the following pending port.
- RESET96_N pulsed low during ISSUE → all OK=0 and MEM_REQ=0 immediately; after release, a stray MEM_RDY produces no OK; a fresh port 0 request completes normally.
- With GFX_ARB_CACHE_EN: port 3 reads 0x100, then re-requests 0x100 → OK[3]=1 one cycle after CS with no MEM_REQ. A request to 0x101 issues MEM_REQ. Without the macro, both requests issue MEM_REQ.

Source files
------------

// File: rtl/gfx_rom_arbiter.sv
// Round-robin 4-port CS/OK read responder onto one outstanding SDRAM read; OK 2+ cycles after CS, held until CS drops.
// Optional GFX_ARB_CACHE_EN: per-port last-address tag answers repeat reads in 1 cycle without a memory access.
module gfx_rom_arbiter #(
    parameter int AW = 22,
    parameter int DW = 32
) (
    input  logic            CLK96,
    input  logic            RESET96_N,
    input  logic [3:0]      P_CS,
    input  logic [4*AW-1:0] P_ADDR,
    output logic [3:0]      P_OK,
    output logic [4*DW-1:0] P_DOUT,
    output logic            MEM_REQ,
    output logic [AW-1:0]   MEM_ADDR,
    input  logic            MEM_RDY,
    input  logic [DW-1:0]   MEM_DATA
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t          state_q;
    logic [1:0]      win_q;
    logic [1:0]      rr_q;
    logic            abort_q;
    logic            mem_req_q;
    logic [AW-1:0]   mem_addr_q;
    logic [3:0]      ok_q;
    logic [3:0]      ok_d;
    logic [DW-1:0]   dout_q [4];
    logic [AW-1:0]   port_addr [4];

    logic [3:0]      granted;
    logic [3:0]      pending;
    logic [3:0]      hit;
    logic [3:0]      cand;
    logic            complete;
    logic            pick_vld;
    logic [1:0]      pick_idx;
    logic [1:0]      idx;

    for (genvar g = 0; g < 4; g++) begin : g_port
        assign port_addr[g]       = P_ADDR[g*AW +: AW];
        assign P_DOUT[g*DW +: DW] = dout_q[g];
    end

`ifdef GFX_ARB_CACHE_EN
    logic [AW-1:0]   tag_q [4];
    logic [3:0]      tag_vld_q;

    always_comb begin
        hit = '0;
        for (int n = 0; n < 4; n++) begin
            hit[n] = (state_q == S_IDLE) && pending[n] && tag_vld_q[n] &&
                     (tag_q[n] == port_addr[n]);
        end
    end
`else
    assign hit = '0;
`endif

    always_comb begin
        granted  = (state_q == S_IDLE) ? 4'b0000 : (4'b0001 << win_q);
        pending  = P_CS & ~ok_q & ~granted;
        cand     = pending & ~hit;
        pick_vld = 1'b0;
        pick_idx = rr_q;
        idx      = '0;
        // Search starts one past the last granted port; i=4 wraps back to rr_q itself.
        for (int i = 1; i <= 4; i++) begin
            idx = rr_q + 2'(i);
            if (!pick_vld && cand[idx]) begin
                pick_vld = 1'b1;
                pick_idx = idx;
            end
        end
        complete = (state_q == S_ISSUE) && MEM_RDY && !abort_q && P_CS[win_q];
        ok_d     = (ok_q & P_CS) | hit | (complete ? (4'b0001 << win_q) : 4'b0000);
    end

    always_ff @(posedge CLK96 or negedge RESET96_N) begin
        if (!RESET96_N) begin
            state_q    <= S_IDLE;
            win_q      <= 2'd0;
            rr_q       <= 2'd3;
            abort_q    <= 1'b0;
            mem_req_q  <= 1'b0;
            mem_addr_q <= '0;
            ok_q       <= '0;
            for (int n = 0; n < 4; n++) dout_q[n] <= '0;
`ifdef GFX_ARB_CACHE_EN
            for (int n = 0; n < 4; n++) tag_q[n] <= '0;
            tag_vld_q  <= '0;
`endif
        end else begin
            ok_q <= ok_d;
            case (state_q)
                S_IDLE: begin
                    if (pick_vld) begin
                        win_q      <= pick_idx;
                        mem_addr_q <= port_addr[pick_idx];
                        mem_req_q  <= 1'b1;
                        abort_q    <= 1'b0;
                        state_q    <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    // A dropped CS is remembered so a later re-raise cannot revive this read.
                    if (!P_CS[win_q]) abort_q <= 1'b1;
                    if (MEM_RDY) begin
                        mem_req_q <= 1'b0;
                        state_q   <= S_DONE;
                        if (complete) begin
                            dout_q[win_q] <= MEM_DATA;
`ifdef GFX_ARB_CACHE_EN
                            tag_q[win_q]     <= mem_addr_q;
                            tag_vld_q[win_q] <= 1'b1;
`endif
                        end
                    end
                end
                S_DONE: begin
                    rr_q    <= win_q;
                    state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign P_OK     = ok_q;
    assign MEM_REQ  = mem_req_q;
    assign MEM_ADDR = mem_addr_q;

endmodule

// File: tb/tb_gfx_rom_arbiter.sv
// Directed bench for gfx_rom_arbiter: stimulus pushes expected memory addresses and OK/data
// responses into queues; a monitor pops them on each MEM_REQ / OK rising edge.
module tb_gfx_rom_arbiter;
    localparam int AW = 22;
    localparam int DW = 32;

    typedef struct packed {
        logic [1:0]    port;
        logic [DW-1:0] data;
    } ok_exp_t;

    logic            CLK96 = 1'b0;
    logic            RESET96_N = 1'b0;
    logic [3:0]      P_CS = '0;
    logic [4*AW-1:0] P_ADDR = '0;
    logic [3:0]      P_OK;
    logic [4*DW-1:0] P_DOUT;
    logic            MEM_REQ;
    logic [AW-1:0]   MEM_ADDR;
    logic            MEM_RDY;
    logic [DW-1:0]   MEM_DATA;

    int n_checks = 0;
    int n_fail   = 0;

    logic [AW-1:0] exp_addr [$];
    ok_exp_t       exp_ok   [$];

    bit mem_auto  = 1'b1;
    int mem_lat   = 3;
    int stray_req = 0;

    gfx_rom_arbiter #(.AW(AW), .DW(DW)) dut (
        .CLK96     (CLK96),
        .RESET96_N (RESET96_N),
        .P_CS      (P_CS),
        .P_ADDR    (P_ADDR),
        .P_OK      (P_OK),
        .P_DOUT    (P_DOUT),
        .MEM_REQ   (MEM_REQ),
        .MEM_ADDR  (MEM_ADDR),
        .MEM_RDY   (MEM_RDY),
        .MEM_DATA  (MEM_DATA)
    );

    initial forever #5 CLK96 = ~CLK96;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Memory word contents: 0xF1400000 | addr, except one special location.
    function automatic logic [DW-1:0] mem_word(input logic [AW-1:0] a);
        if (a == 22'h12345) return 32'hDEADBEEF;
        return {10'h3C5, a};
    endfunction

    // SDRAM responder: MEM_RDY pulses in the mem_lat-th cycle of MEM_REQ.
    initial begin
        int age;
        int stray_done;
        age = 0;
        stray_done = 0;
        MEM_RDY = 1'b0;
        MEM_DATA = '0;
        forever begin
            @(posedge CLK96); #1;
            MEM_RDY = 1'b0;
            if (stray_done != stray_req) begin
                stray_done = stray_req;
                MEM_RDY  = 1'b1;
                MEM_DATA = 32'hBAD0BAD0;
            end else if (mem_auto && MEM_REQ) begin
                if (age >= mem_lat - 1) begin
                    MEM_RDY  = 1'b1;
                    MEM_DATA = mem_word(MEM_ADDR);
                    age = 0;
                end else begin
                    age++;
                end
            end else begin
                age = 0;
            end
        end
    end

    // Monitor: every rising OK / MEM_REQ must match the head of its queue.
    initial begin
        logic [3:0] prev_ok;
        logic       prev_req;
        ok_exp_t    e;
        prev_ok  = '0;
        prev_req = 1'b0;
        forever begin
            @(negedge CLK96);
            for (int p = 0; p < 4; p++) begin
                if (P_OK[p] && !prev_ok[p]) begin
                    if (exp_ok.size() == 0) begin
                        check("unexpected_ok", 64'(p), 64'hFF);
                    end else begin
                        e = exp_ok.pop_front();
                        check("ok_port", 64'(p), 64'(e.port));
                        check("ok_dout", 64'(P_DOUT[p*DW +: DW]), 64'(e.data));
                    end
                end
            end
            if (MEM_REQ && !prev_req) begin
                if (exp_addr.size() == 0) check("unexpected_mem_req", 64'(MEM_ADDR), 64'hFFFF_FFFF);
                else check("mem_addr", 64'(MEM_ADDR), 64'(exp_addr.pop_front()));
            end
            prev_ok  = P_OK;
            prev_req = MEM_REQ;
        end
    end

    task automatic exp_read(input int p, input logic [AW-1:0] a, input logic [DW-1:0] d);
        exp_addr.push_back(a);
        exp_ok.push_back('{port: 2'(p), data: d});
    endtask

    task automatic raise(input int p, input logic [AW-1:0] a);
        @(posedge CLK96); #1;
        P_ADDR[p*AW +: AW] = a;
        P_CS[p] = 1'b1;
    endtask

    task automatic wait_ok(input int p, input int budget, output int lat);
        lat = -1;
        for (int c = 0; c < budget; c++) begin
            @(negedge CLK96);
            if (P_OK[p]) begin
                lat = c;
                break;
            end
        end
        if (lat < 0) check("ok_timeout", 64'(P_OK[p]), 64'd1);
    endtask

    task automatic drop(input int p);
        @(posedge CLK96); #1;
        P_CS[p] = 1'b0;
        @(negedge CLK96);
        check("ok_hold_at_drop", 64'(P_OK[p]), 64'd1);
        @(negedge CLK96);
        check("ok_clear_after_drop", 64'(P_OK[p]), 64'd0);
    endtask

    task automatic do_reset();
        @(posedge CLK96); #1;
        RESET96_N = 1'b0;
        P_CS = '0;
        repeat (2) @(posedge CLK96);
        #1 RESET96_N = 1'b1;
    endtask

    initial begin
        int lat;
        bit [3:0] seen;
        int hold [4];
        logic [3:0] drop_m;

        // Reset state
        #2;
        check("rst_ok", 64'(P_OK), 64'd0);
        check("rst_mem_req", 64'(MEM_REQ), 64'd0);
        check("rst_mem_addr", 64'(MEM_ADDR), 64'd0);
        check("rst_dout_zero", 64'(P_DOUT == '0), 64'd1);
        repeat (2) @(posedge CLK96);
        #1 RESET96_N = 1'b1;

        // Single request on port 2, MEM_RDY in cycle 3 -> OK in cycle 4
        mem_lat = 3;
        exp_read(2, 22'h12345, 32'hDEADBEEF);
        raise(2, 22'h12345);
        wait_ok(2, 20, lat);
        check("latency_port2", 64'(lat), 64'd4);
        drop(2);

        // All four ports from reset: served 0,1,2,3, each OK held while CS high
        do_reset();
        exp_read(0, 22'h1000, 32'hF1401000);
        exp_read(1, 22'h2001, 32'hF1402001);
        exp_read(2, 22'h3002, 32'hF1403002);
        exp_read(3, 22'h4003, 32'hF1404003);
        @(posedge CLK96); #1;
        P_ADDR = {22'h4003, 22'h3002, 22'h2001, 22'h1000};
        P_CS = 4'hF;
        seen = '0;
        for (int p = 0; p < 4; p++) hold[p] = 0;
        for (int c = 0; c < 150 && P_CS != 4'h0; c++) begin
            @(negedge CLK96);
            drop_m = '0;
            for (int p = 0; p < 4; p++) begin
                if (P_CS[p]) begin
                    if (seen[p]) check("ok_held", 64'(P_OK[p]), 64'd1);
                    else if (P_OK[p]) seen[p] = 1'b1;
                    if (seen[p]) hold[p]++;
                    if (hold[p] >= 3) drop_m[p] = 1'b1;
                end
            end
            @(posedge CLK96); #1;
            P_CS = P_CS & ~drop_m;
        end
        check("all_ports_served", 64'(seen), 64'hF);
        repeat (2) @(negedge CLK96);
        check("all_ok_cleared", 64'(P_OK), 64'd0);

        // Abort: port 1 drops CS during ISSUE, port 2 is served next
        mem_lat = 4;
        exp_addr.push_back(22'h2222);
        exp_read(2, 22'h3333, 32'hF1403333);
        @(posedge CLK96); #1;
        P_ADDR[1*AW +: AW] = 22'h2222;
        P_ADDR[2*AW +: AW] = 22'h3333;
        P_CS[2:1] = 2'b11;
        repeat (2) @(posedge CLK96);
        #1 P_CS[1] = 1'b0;
        wait_ok(2, 40, lat);
        check("abort_ok1_low", 64'(P_OK[1]), 64'd0);
        check("abort_dout1_kept", 64'(P_DOUT[1*DW +: DW]), 64'hF1402001);
        drop(2);

        // CS falls in the same cycle as MEM_RDY: still an abort
        mem_lat = 3;
        exp_addr.push_back(22'h2224);
        raise(1, 22'h2224);
        repeat (3) @(posedge CLK96);
        #1 P_CS[1] = 1'b0;
        repeat (6) @(negedge CLK96);
        check("same_cycle_abort_ok1", 64'(P_OK[1]), 64'd0);
        check("same_cycle_abort_dout1", 64'(P_DOUT[1*DW +: DW]), 64'hF1402001);

        // Reset during ISSUE, stray MEM_RDY afterwards, then a fresh request
        mem_auto = 1'b0;
        exp_addr.push_back(22'h5555);
        raise(0, 22'h5555);
        repeat (2) @(posedge CLK96);
        #1 RESET96_N = 1'b0;
        P_CS[0] = 1'b0;
        @(negedge CLK96);
        check("midrst_mem_req", 64'(MEM_REQ), 64'd0);
        check("midrst_ok", 64'(P_OK), 64'd0);
        check("midrst_dout_zero", 64'(P_DOUT == '0), 64'd1);
        @(posedge CLK96);
        #1 RESET96_N = 1'b1;
        @(posedge CLK96);
        #1 stray_req++;
        repeat (5) @(negedge CLK96);
        check("stray_rdy_no_ok", 64'(P_OK), 64'd0);
        check("stray_rdy_no_req", 64'(MEM_REQ), 64'd0);
        mem_auto = 1'b1;
        mem_lat = 2;
        exp_read(0, 22'h6006, 32'hF1406006);
        raise(0, 22'h6006);
        wait_ok(0, 20, lat);
        check("fresh_latency_port0", 64'(lat), 64'd3);
        drop(0);

        // Repeat-address reads on port 3
        mem_lat = 3;
        exp_read(3, 22'h100, 32'hF1400100);
        raise(3, 22'h100);
        wait_ok(3, 20, lat);
        drop(3);
`ifdef GFX_ARB_CACHE_EN
        exp_ok.push_back('{port: 2'd3, data: 32'hF1400100});
        raise(3, 22'h100);
        wait_ok(3, 20, lat);
        check("hit_latency", 64'(lat), 64'd1);
        check("hit_no_mem_req", 64'(MEM_REQ), 64'd0);
`else
        exp_read(3, 22'h100, 32'hF1400100);
        raise(3, 22'h100);
        wait_ok(3, 20, lat);
        check("repeat_latency", 64'(lat), 64'd4);
`endif
        drop(3);
        exp_read(3, 22'h101, 32'hF1400101);
        raise(3, 22'h101);
        wait_ok(3, 20, lat);
        check("miss_latency", 64'(lat), 64'd4);
        drop(3);

        repeat (4) @(negedge CLK96);
        check("addr_queue_drained", 64'(exp_addr.size()), 64'd0);
        check("ok_queue_drained", 64'(exp_ok.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
